// File: rtl/rand_arb_pkg.sv
// Shared definitions for the round-robin random-number arbiter:
// LFSR width and taps, arbiter state encoding and the LFSR step function.
package rand_arb_pkg;

    localparam int LFSR_W = 8;

    // Taps at bits 7, 5, 4 and 3.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    typedef enum logic {
        WARM,
        READY
    } arb_state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/rand_lfsr_step.sv
// Fibonacci LFSR register with a step enable and a synchronous load.
// Any load of zero is replaced by 1, so the register never locks up at 0.
module rand_lfsr_step
    import rand_arb_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'h01
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_data,
    input  logic              step,
    output logic [LFSR_W-1:0] value
);

    localparam logic [LFSR_W-1:0] ONE       = LFSR_W'(1);
    localparam logic [LFSR_W-1:0] SAFE_SEED = (SEED == '0) ? ONE : SEED;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= SAFE_SEED;
        end else if (load) begin
            value <= (load_data == '0) ? ONE : load_data;
        end else if (step) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/rand_arbiter.sv
// Round-robin arbiter handing out one fresh LFSR value per grant, with
// seed loading and post-seed warm-up. Optional macro RAND_ARB_FREERUN_EN
// makes the LFSR also step on idle READY cycles.
module rand_arbiter
    import rand_arb_pkg::*;
#(
    parameter int                NUM_REQ = 4,
    parameter logic [LFSR_W-1:0] SEED    = 8'h01,
    parameter int                WARMUP  = 8
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               seed_valid,
    input  logic [LFSR_W-1:0]  seed_data,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               rnd_valid,
    output logic [LFSR_W-1:0]  rnd_data,
    output logic               busy
);

    localparam int                PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0]        WARM_INIT  = 8'(WARMUP);
    localparam bit                HAS_WARMUP = (WARMUP > 0);
    localparam logic [NUM_REQ-1:0] ONEHOT0   = {{(NUM_REQ-1){1'b0}}, 1'b1};

    // First set bit of elig at or above ptr, wrapping around. The loop runs
    // downward so the lowest offset from ptr is written last and wins.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                                  input logic [PTR_W-1:0]   ptr);
        logic [PTR_W-1:0] win;
        win = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr) + k) % NUM_REQ;
            if (elig[idx]) win = PTR_W'(idx);
        end
        return win;
    endfunction

    arb_state_t         state;
    logic [7:0]         warm_cnt;
    logic [PTR_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] eligible;
    logic [PTR_W-1:0]   winner;
    logic               grant_now;
    logic               lfsr_step;
    logic [LFSR_W-1:0]  lfsr;

    // A requester granted last cycle is masked so it cannot win twice in a row
    // on a req it has not yet had time to drop.
    assign eligible  = req & ~gnt;
    assign winner    = rr_pick(eligible, rr_ptr);
    assign grant_now = (state == READY) && (eligible != '0) && !seed_valid;

`ifdef RAND_ARB_FREERUN_EN
    // Both states step on every cycle; a seed load overrides the step.
    assign lfsr_step = 1'b1;
`else
    assign lfsr_step = (state == WARM) || grant_now;
`endif

    rand_lfsr_step #(
        .SEED (SEED)
    ) u_lfsr (
        .clk       (clk),
        .reset     (reset),
        .load      (seed_valid),
        .load_data (seed_data),
        .step      (lfsr_step),
        .value     (lfsr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= HAS_WARMUP ? WARM : READY;
            warm_cnt <= WARM_INIT;
            rr_ptr   <= '0;
            gnt      <= '0;
            rnd_data <= '0;
        end else if (seed_valid) begin
            state    <= HAS_WARMUP ? WARM : READY;
            warm_cnt <= WARM_INIT;
            gnt      <= '0;
        end else if (state == WARM) begin
            gnt      <= '0;
            warm_cnt <= warm_cnt - 8'd1;
            if (warm_cnt == 8'd1) state <= READY;
        end else if (grant_now) begin
            gnt      <= ONEHOT0 << winner;
            rnd_data <= lfsr;
            rr_ptr   <= PTR_W'((int'(winner) + 1) % NUM_REQ);
        end else begin
            gnt      <= '0;
        end
    end

    assign rnd_valid = |gnt;
    assign busy      = (state == WARM);

endmodule

// File: tb/tb_rand_arbiter.sv
// Directed bench for rand_arbiter: two instances (WARMUP=8 and WARMUP=0)
// share stimulus and are checked every cycle against a behavioural model.
module tb_rand_arbiter;

`ifdef RAND_ARB_FREERUN_EN
    localparam bit FREERUN = 1'b1;
`else
    localparam bit FREERUN = 1'b0;
`endif

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       seed_valid = 1'b0;
    logic [7:0] seed_data  = 8'h00;
    logic [3:0] req        = 4'b0000;

    logic [3:0] gnt_w8, gnt_w0;
    logic       rnd_valid_w8, rnd_valid_w0;
    logic [7:0] rnd_data_w8, rnd_data_w0;
    logic       busy_w8, busy_w0;

    int n_checks = 0;
    int n_errors = 0;

    initial forever #5 clk = ~clk;

    rand_arbiter #(.NUM_REQ(4), .SEED(8'h01), .WARMUP(8)) dut_w8 (
        .clk        (clk),
        .reset      (reset),
        .seed_valid (seed_valid),
        .seed_data  (seed_data),
        .req        (req),
        .gnt        (gnt_w8),
        .rnd_valid  (rnd_valid_w8),
        .rnd_data   (rnd_data_w8),
        .busy       (busy_w8)
    );

    rand_arbiter #(.NUM_REQ(4), .SEED(8'h01), .WARMUP(0)) dut_w0 (
        .clk        (clk),
        .reset      (reset),
        .seed_valid (seed_valid),
        .seed_data  (seed_data),
        .req        (req),
        .gnt        (gnt_w0),
        .rnd_valid  (rnd_valid_w0),
        .rnd_data   (rnd_data_w0),
        .busy       (busy_w0)
    );

    task automatic check(input string name, input logic [31:0] actual, input int expected);
        n_checks++;
        if (actual !== 32'(expected)) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model (index 0: WARMUP=8, 1: WARMUP=0)
    int m_lfsr [2];
    int m_warm [2];   // warm-up steps still to run
    int m_rr   [2];
    int m_gnt  [2];
    int m_rnd  [2];

    function automatic int lfsr_adv(input int v);
        int fb;
        fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
        return ((v << 1) & 'hFE) | fb;
    endfunction

    task automatic model_step(input int i);
        int warmup;
        int elig;
        warmup = (i == 0) ? 8 : 0;
        if (reset) begin
            m_lfsr[i] = 1;
            m_warm[i] = warmup;
            m_rr[i]   = 0;
            m_gnt[i]  = 0;
            m_rnd[i]  = 0;
        end else if (seed_valid) begin
            m_lfsr[i] = (seed_data == 8'h00) ? 1 : int'(seed_data);
            m_warm[i] = warmup;
            m_gnt[i]  = 0;
        end else if (m_warm[i] > 0) begin
            m_lfsr[i] = lfsr_adv(m_lfsr[i]);
            m_warm[i] = m_warm[i] - 1;
            m_gnt[i]  = 0;
        end else begin
            elig = int'(req) & ~m_gnt[i] & 'hF;
            m_gnt[i] = 0;
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx = (m_rr[i] + k) % 4;
                if (m_gnt[i] == 0 && elig[idx]) begin
                    m_gnt[i]  = 1 << idx;
                    m_rnd[i]  = m_lfsr[i];
                    m_lfsr[i] = lfsr_adv(m_lfsr[i]);
                    m_rr[i]   = (idx + 1) % 4;
                end
            end
            if (m_gnt[i] == 0 && FREERUN) m_lfsr[i] = lfsr_adv(m_lfsr[i]);
        end
    endtask

    task automatic compare_inst(input string tag, input int i, input logic [3:0] g,
                                input logic rv, input logic [7:0] rd, input logic b);
        check({tag, ".gnt"}, 32'(g), m_gnt[i]);
        check({tag, ".rnd_valid"}, 32'(rv), (m_gnt[i] != 0) ? 1 : 0);
        check({tag, ".busy"}, 32'(b), (m_warm[i] > 0) ? 1 : 0);
        if (m_gnt[i] != 0) check({tag, ".rnd_data"}, 32'(rd), m_rnd[i]);
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        #1;
        compare_inst("w8", 0, gnt_w8, rnd_valid_w8, rnd_data_w8, busy_w8);
        compare_inst("w0", 1, gnt_w0, rnd_valid_w0, rnd_data_w0, busy_w0);
    end

    // ---------------- directed stimulus with literal expectations
    task automatic drive(input logic r, input logic sv, input logic [7:0] sd, input logic [3:0] rq);
        reset      = r;
        seed_valid = sv;
        seed_data  = sd;
        req        = rq;
        @(posedge clk);
        #2;
    endtask

    logic [3:0] rr_gnt_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] rr_rnd_exp [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    int busy_cnt;
    int starved;

    initial begin
        // Reset values
        drive(1'b1, 1'b0, 8'h00, 4'b0000);
        drive(1'b1, 1'b0, 8'h00, 4'b0000);
        check("rst.gnt_w8", 32'(gnt_w8), 0);
        check("rst.gnt_w0", 32'(gnt_w0), 0);
        check("rst.rnd_valid_w8", 32'(rnd_valid_w8), 0);
        check("rst.rnd_data_w8", 32'(rnd_data_w8), 0);
        check("rst.rnd_data_w0", 32'(rnd_data_w0), 0);
        check("rst.busy_w8", 32'(busy_w8), 1);
        check("rst.busy_w0", 32'(busy_w0), 0);

        // Warm-up: busy for 8 cycles from release, then 1C and 38 (71 free-running)
        busy_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (busy_w8) busy_cnt++;
            drive(1'b0, 1'b0, 8'h00, 4'b0001);
        end
        check("warm.busy_cycles", 32'(busy_cnt), 8);
        check("warm.busy_after", 32'(busy_w8), 0);
        drive(1'b0, 1'b0, 8'h00, 4'b0001);
        check("warm.first_gnt", 32'(gnt_w8), 4'b0001);
        check("warm.first_rnd", 32'(rnd_data_w8), 8'h1C);
        drive(1'b0, 1'b0, 8'h00, 4'b0001);
        check("warm.masked_gnt", 32'(gnt_w8), 0);
        drive(1'b0, 1'b0, 8'h00, 4'b0001);
        check("warm.second_gnt", 32'(gnt_w8), 4'b0001);
        check("warm.second_rnd", 32'(rnd_data_w8), FREERUN ? 8'h71 : 8'h38);

        // Round-robin on the WARMUP=0 instance, then reset while gnt=0100
        drive(1'b1, 1'b0, 8'h00, 4'b0000);
        for (int k = 0; k < 11; k++) begin
            drive(1'b0, 1'b0, 8'h00, 4'b1111);
            if (k < 5) begin
                check("rr.gnt", 32'(gnt_w0), int'(rr_gnt_exp[k]));
                check("rr.rnd", 32'(rnd_data_w0), int'(rr_rnd_exp[k]));
            end
        end
        check("midrst.pre_gnt_w8", 32'(gnt_w8), 4'b0100);
        check("midrst.pre_gnt_w0", 32'(gnt_w0), 4'b0100);
        drive(1'b1, 1'b0, 8'h00, 4'b1111);
        check("midrst.gnt_w8", 32'(gnt_w8), 0);
        check("midrst.gnt_w0", 32'(gnt_w0), 0);
        drive(1'b0, 1'b0, 8'h00, 4'b1111);
        check("midrst.w0_gnt", 32'(gnt_w0), 4'b0001);
        check("midrst.w0_rnd", 32'(rnd_data_w0), 8'h01);
        for (int k = 0; k < 8; k++) drive(1'b0, 1'b0, 8'h00, 4'b1111);
        check("midrst.w8_gnt", 32'(gnt_w8), 4'b0001);
        check("midrst.w8_rnd", 32'(rnd_data_w8), 8'h1C);

        // Fairness with req=1010 from rr_ptr=0
        drive(1'b1, 1'b0, 8'h00, 4'b0000);
        starved = 0;
        for (int k = 0; k < 12; k++) begin
            drive(1'b0, 1'b0, 8'h00, 4'b1010);
            check("fair.gnt", 32'(gnt_w0), (k % 2 == 0) ? 4'b0010 : 4'b1000);
            if (gnt_w0[0] || gnt_w0[2] || gnt_w8[0] || gnt_w8[2]) starved++;
        end
        check("fair.never_0_or_2", 32'(starved), 0);

        // Zero seed alongside a pending request, then 3 idle cycles
        drive(1'b0, 1'b1, 8'h00, 4'b0001);
        check("seed.gnt_w8", 32'(gnt_w8), 0);
        check("seed.gnt_w0", 32'(gnt_w0), 0);
        check("seed.busy_w8", 32'(busy_w8), 1);
        check("seed.busy_w0", 32'(busy_w0), 0);
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 8'h00, 4'b0000);
        drive(1'b0, 1'b0, 8'h00, 4'b0001);
        check("seed.w0_gnt", 32'(gnt_w0), 4'b0001);
        check("seed.w0_rnd", 32'(rnd_data_w0), FREERUN ? 8'h08 : 8'h01);
        for (int k = 0; k < 5; k++) drive(1'b0, 1'b0, 8'h00, 4'b0001);
        check("seed.w8_gnt", 32'(gnt_w8), 4'b0001);
        check("seed.w8_rnd", 32'(rnd_data_w8), 8'h1C);

        // Non-zero seed followed by mixed request patterns (model-checked)
        drive(1'b0, 1'b1, 8'hA5, 4'b0110);
        for (int k = 0; k < 14; k++) drive(1'b0, 1'b0, 8'h00, 4'(k * 5 + 3));
        drive(1'b0, 1'b0, 8'h00, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
